dct_zz_reader: RTL

Drains the 8x8 signed coefficient block produced by `dct_top` and serializes it in JPEG zigzag order over a valid/ready stream for the downstream quantizer/entropy coder. The block is captured in one cycle on the `dct_done` pulse. Coefficients are then read out one per accepted handshake. The reader sits directly after `dct_top` in the compression pipeline.

---
 rtl/dct_zz_reader_if.sv | 21 ++
 rtl/dct_zz_reader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dct_zz_reader_if.sv
// Zigzag coefficient stream between dct_zz_reader (master) and the quantizer/entropy coder (slave).
interface dct_zz_reader_if #(
   parameter int CW = 11
);
   logic signed [CW-1:0] zz_data;
   logic [5:0]           zz_idx;
   logic [5:0]           zz_pos;
   logic                 zz_valid;
   logic                 zz_ready;
   logic                 zz_last;

   modport master (
      output zz_data, zz_idx, zz_pos, zz_valid, zz_last,
      input  zz_ready
   );

   modport slave (
      input  zz_data, zz_idx, zz_pos, zz_valid, zz_last,
      output zz_ready
   );
endinterface

// File: rtl/dct_zz_reader.sv
// Captures an 8x8 DCT block on dct_done and streams it out in JPEG zigzag order.
// Optional second capture buffer when DCT_ZZ_DBUF_EN is defined.
module dct_zz_reader #(
   parameter int CW = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      dct_done,
   input  logic [7:0][7:0][CW-1:0]   coef_in,
   dct_zz_reader_if.master           zz,
   output logic                      busy,
   output logic                      overrun
);

   typedef enum logic {IDLE, SEND} state_t;

   // Zigzag index k -> natural position r*8+c
   localparam logic [5:0] ZZ_POS [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   state_t        state_reg;
   logic [5:0]    k_reg;
   logic          valid_reg;
   logic          overrun_reg;

   logic          hs;
   logic          fin;
   logic          cap_en;
   logic          ovr_set;
   logic [5:0]    rd_pos;
   logic [CW-1:0] rd_data;

   assign hs     = valid_reg & zz.zz_ready;
   assign fin    = hs & (k_reg == 6'd63);
   assign rd_pos = ZZ_POS[k_reg];

`ifdef DCT_ZZ_DBUF_EN
   logic          act_reg;
   logic          pend_reg;
   logic          cap_sel;
   logic [CW-1:0] mem [2][64];

   // A buffer being finished this cycle counts as free
   assign cap_en  = dct_done & ((state_reg == IDLE) | ~pend_reg | fin);
   assign cap_sel = (state_reg == SEND && !pend_reg) ? ~act_reg : act_reg;
   assign rd_data = mem[act_reg][rd_pos];
   assign busy    = valid_reg | pend_reg;

   always_ff @(posedge clk) begin
      if (cap_en) begin
         for (int i = 0; i < 64; i++) begin
            mem[cap_sel][i[5:0]] <= coef_in[i[5:3]][i[2:0]];
         end
      end
   end
`else
   logic [CW-1:0] mem [64];

   assign cap_en  = dct_done & ((state_reg == IDLE) | fin);
   assign rd_data = mem[rd_pos];
   assign busy    = valid_reg;

   always_ff @(posedge clk) begin
      if (cap_en) begin
         for (int i = 0; i < 64; i++) begin
            mem[i[5:0]] <= coef_in[i[5:3]][i[2:0]];
         end
      end
   end
`endif

   assign ovr_set = dct_done & ~cap_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         k_reg       <= 6'd0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
`ifdef DCT_ZZ_DBUF_EN
         act_reg     <= 1'b0;
         pend_reg    <= 1'b0;
`endif
      end else begin
         overrun_reg <= overrun_reg | ovr_set;
         case (state_reg)
            IDLE: begin
               if (dct_done) begin
                  state_reg <= SEND;
                  valid_reg <= 1'b1;
                  k_reg     <= 6'd0;
               end
            end
            SEND: begin
`ifdef DCT_ZZ_DBUF_EN
               if (dct_done && !pend_reg && !fin) begin
                  pend_reg <= 1'b1;
               end
`endif
               if (hs) begin
                  if (k_reg != 6'd63) begin
                     k_reg <= k_reg + 6'd1;
                  end else begin
                     k_reg <= 6'd0;
`ifdef DCT_ZZ_DBUF_EN
                     // Pending block takes over; a simultaneous new block refills the freed buffer
                     if (pend_reg) begin
                        act_reg  <= ~act_reg;
                        pend_reg <= dct_done;
                     end else if (dct_done) begin
                        act_reg  <= ~act_reg;
                     end else begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                     end
`else
                     if (!dct_done) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                     end
`endif
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign overrun     = overrun_reg;
   assign zz.zz_valid = valid_reg;
   assign zz.zz_idx   = valid_reg ? k_reg : 6'd0;
   assign zz.zz_pos   = valid_reg ? rd_pos : 6'd0;
   assign zz.zz_last  = valid_reg & (k_reg == 6'd63);
   assign zz.zz_data  = valid_reg ? rd_data : '0;

endmodule
